// File: rtl/cash_entry.sv
`default_nettype none
// ============================================================================
//  Module   : cash_entry
//  Purpose  : Digit-serial decimal amount entry. Accepts BCD digits one at a
//             time over a valid/ready handshake, accumulates them into a
//             binary cash amount and flags the result as final or invalid.
//             This is the inverse of the payout decode path (binary sum to
//             hundreds/tens/units).
//  Ports    : clk          - system clock, rising edge
//             reset        - synchronous active-high reset
//             clear        - abort/finish entry, return to IDLE
//             digit_in     - BCD digit
//             digit_valid  - digit_in presented this cycle
//             digit_ready  - block can take a digit this cycle
//             enter        - operator confirms the entry
//             sum          - accumulated binary amount
//             sum_valid    - amount final and legal (DONE)
//             err          - entry invalid (ERROR)
//             ndigits      - digits accepted so far
//             echo100/echo010/echo001 - digit echo (CASH_ENTRY_ECHO_EN only)
//  Options  : CASH_ENTRY_ECHO_EN adds the right-aligned digit echo outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module cash_entry #(
   parameter int unsigned MAX_DIGITS = 3,
   parameter int unsigned MAX_SUM    = 799
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   output logic       digit_ready,
   input  logic       enter,
   output logic [9:0] sum,
   output logic       sum_valid,
   output logic       err,
`ifdef CASH_ENTRY_ECHO_EN
   output logic [2:0] echo100,
   output logic [3:0] echo010,
   output logic [3:0] echo001,
`endif
   output logic [1:0] ndigits
);

   localparam logic [1:0]  c_MAX_DIGITS = MAX_DIGITS[1:0];
   localparam logic [13:0] c_MAX_SUM    = MAX_SUM[13:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [9:0]  r_sum;
   logic [9:0]  w_sum_nxt;
   logic [1:0]  r_ndigits;
   logic [1:0]  w_ndigits_nxt;
   logic [13:0] w_calc;
   logic        w_accept;
   logic        w_bad;

`ifdef CASH_ENTRY_ECHO_EN
   logic [2:0]  r_echo100;
   logic [3:0]  r_echo010;
   logic [3:0]  r_echo001;
   logic [2:0]  w_echo100_nxt;
   logic [3:0]  w_echo010_nxt;
   logic [3:0]  w_echo001_nxt;
`endif

   // Ready is decoded from state and digit count; held low while reset is
   // asserted so nothing is handshaken during the reset cycle.
   always_comb begin
      digit_ready = 1'b0;
      if (!reset) begin
         if (r_state == S_IDLE)
            digit_ready = 1'b1;
         else if (r_state == S_ENTRY && r_ndigits < c_MAX_DIGITS)
            digit_ready = 1'b1;
      end
   end

   assign w_accept = digit_valid & digit_ready;

   // sum*10 + digit as two shifts and an add, wide enough never to wrap.
   assign w_calc = ({4'd0, r_sum} << 3) + ({4'd0, r_sum} << 1) + {10'd0, digit_in};
   assign w_bad  = (digit_in > 4'd9) || (w_calc > c_MAX_SUM);

   always_comb begin
      w_state_nxt   = r_state;
      w_sum_nxt     = r_sum;
      w_ndigits_nxt = r_ndigits;
`ifdef CASH_ENTRY_ECHO_EN
      w_echo100_nxt = r_echo100;
      w_echo010_nxt = r_echo010;
      w_echo001_nxt = r_echo001;
`endif
      if (clear) begin
         w_state_nxt   = S_IDLE;
         w_sum_nxt     = 10'd0;
         w_ndigits_nxt = 2'd0;
`ifdef CASH_ENTRY_ECHO_EN
         w_echo100_nxt = 3'd0;
         w_echo010_nxt = 4'd0;
         w_echo001_nxt = 4'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_ENTRY: begin
               if (w_accept) begin
                  if (w_bad) begin
                     // Sum keeps its last legal value.
                     w_state_nxt = S_ERROR;
                  end else begin
                     w_sum_nxt     = w_calc[9:0];
                     w_ndigits_nxt = r_ndigits + 2'd1;
`ifdef CASH_ENTRY_ECHO_EN
                     w_echo100_nxt = r_echo010[2:0];
                     w_echo010_nxt = r_echo001;
                     w_echo001_nxt = digit_in;
`endif
                     // A digit arriving with enter is folded in first.
                     w_state_nxt   = enter ? S_DONE : S_ENTRY;
                  end
               end else if (enter) begin
                  w_state_nxt = S_DONE;
               end
            end
            S_DONE, S_ERROR: begin
               // Frozen until clear.
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sum     <= 10'd0;
         r_ndigits <= 2'd0;
`ifdef CASH_ENTRY_ECHO_EN
         r_echo100 <= 3'd0;
         r_echo010 <= 4'd0;
         r_echo001 <= 4'd0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_sum     <= w_sum_nxt;
         r_ndigits <= w_ndigits_nxt;
`ifdef CASH_ENTRY_ECHO_EN
         r_echo100 <= w_echo100_nxt;
         r_echo010 <= w_echo010_nxt;
         r_echo001 <= w_echo001_nxt;
`endif
      end
   end

   assign sum       = r_sum;
   assign ndigits   = r_ndigits;
   assign sum_valid = (r_state == S_DONE);
   assign err       = (r_state == S_ERROR);
`ifdef CASH_ENTRY_ECHO_EN
   assign echo100   = r_echo100;
   assign echo010   = r_echo010;
   assign echo001   = r_echo001;
`endif

endmodule
`default_nettype wire
